melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Sequences a fixed table of square-wave notes into the audio output path and owns the write handshake toward `Audio_Controller`. It steps through `NUM_NOTES` entries and plays each for `NOTE_TICKS` cycles, with a `GAP_TICKS` silence between notes. A sample-rate divider paces the samples, and the block holds `write_audio_out` until `audio_out_allowed` accepts each one. It sits between the top-level switch/key controls and the `Audio_Controller` left/right output data inputs; both channels carry the same sample.

## Interface
Parameters:
- `NUM_NOTES`, 5: number of table entries (1..8).
- `NOTE_TICKS`, 50000000: cycles each note sounds.
- `GAP_TICKS`, 2500000: silent cycles after each note.
- `SAMPLE_DIV`, 1042: cycles per output sample (≈48 kHz at 50 MHz).
- `AMPLITUDE`, 10000000: square-wave magnitude.
- Note table (half-period, in cycles; 0 = rest):
  - idx0 C4 = 95420
  - idx1 D5 = 42589
  - idx2 E5 = 37936
  - idx3 D5 = 42589
  - idx4 C5 = 47801
  - idx5..7 = 0

Ports:
- `CLOCK_50` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; sampled in IDLE/DONE.
- `stop` in 1: level; aborts playback.
- `audio_out_allowed` in 1: output FIFO has space.
- `write_audio_out` out 1: sample valid/write strobe.
- `sample_out` out 32: signed two's-complement sample.
- `busy` out 1: high in LOAD/PLAY/GAP.
- `note_index` out 3: current table index.
- `done` out 1: one-cycle pulse at the end of the table.

## Operation
States: IDLE, LOAD, PLAY, GAP, DONE.
- **IDLE**: `start`=1 → LOAD with `note_index`=0.
- **LOAD** (1 cycle):
  - load `half_period` from the table[`note_index`];
  - clear `dur_cnt` and `half_cnt`;
  - set `phase`=0;
  - → PLAY.
- **PLAY**:
  - `dur_cnt` increments each cycle; at `dur_cnt`==`NOTE_TICKS`-1 → GAP and clear `dur_cnt`.
  - `half_cnt` increments; at `half_cnt`==`half_period`-1, clear it and toggle `phase`.
  - Level = `phase` ? −`AMPLITUDE` : +`AMPLITUDE`; a rest (`half_period`==0) gives level 0 and never toggles.
- **GAP**:
  - level 0;
  - at `dur_cnt`==`GAP_TICKS`-1:
    - if `note_index`==`NUM_NOTES`-1 → DONE with a `done` pulse;
    - otherwise increment `note_index` and → LOAD.
- **DONE**:
  - `start`=0 → IDLE;
  - `start` held high stays in DONE, so a held `start` does not replay.
- `stop`=1 in any non-IDLE state → IDLE next cycle:
  - `note_index`←0;
  - pending sample dropped;
  - `write_audio_out`←0.
  - `stop` takes priority over `start` and over every other transition.

Sample handshake (active in LOAD/PLAY/GAP):
- `samp_cnt` counts 0..`SAMPLE_DIV`-1 free-running while busy.
- At the wrap, the current level is latched into `sample_out` and `write_audio_out` is set (pending).
- `write_audio_out` clears on the first cycle with `audio_out_allowed`=1, so each sample is written exactly once.
- If a new wrap arrives while still pending, `sample_out` is overwritten with the newer level and the request stays pending; there is no queue.

Arithmetic:
- `sample_out` is the 32-bit signed level; −`AMPLITUDE` is 32'hFF676980.
- Counters are wide enough for their parameter (`dur_cnt` 26 bits, `half_cnt` 21 bits, `samp_cnt` 11 bits).
- No wrap beyond the terminal counts.

## Timing
- Reset values:
  - state IDLE;
  - `write_audio_out`=0, `sample_out`=0, `busy`=0, `note_index`=0, `done`=0;
  - all counters 0; `phase`=0.
- Latency:
  - `start` → `busy`=1 on the next edge (LOAD);
  - first PLAY cycle 2 edges after `start`;
  - first `write_audio_out` `SAMPLE_DIV` cycles after entering LOAD.
- `write_audio_out` rises registered and falls the cycle after it is accepted (`allowed` seen high).
- Note boundary: the GAP→LOAD→PLAY transition costs 1 extra cycle (LOAD) per note.
- `done` is high for exactly 1 cycle, coincident with entering DONE; `busy` falls on the same edge.
- Reset asserted mid-play returns every output to its reset value on that edge.

## Configuration
- `MELODY_LOOP_EN` defined:
  - at the last note's GAP end, the block wraps to `note_index`=0 → LOAD and pulses `done`;
  - it never enters DONE while `start` is held;
  - if `start`=0 at the wrap → IDLE instead.
- Undefined: single pass, then DONE as above.

## Test plan
Bench parameters: `NOTE_TICKS`=40, `GAP_TICKS`=8, `SAMPLE_DIV`=4, table halves 5,3,0,2,4.
1. Reset, then a `start` pulse with `allowed`=1 → `busy` at +1 cycle; `sample_out`=+10000000 first, flipping sign every 5 cycles in note 0; `write_audio_out` exactly 1 cycle per 4.
2. Full pass → `note_index` runs 0..4; note 2 emits only 0; `done` pulses once at cycle 2+5·(40+8+1)−1; `busy` falls on the same edge.
3. `allowed`=0 for 10 cycles mid-note → `write_audio_out` stays high holding the newest level; exactly one write once `allowed`=1.
4. `stop` asserted in note 3 together with `start`=1 → IDLE next cycle; `write_audio_out`=0, `note_index`=0.
5. Synchronous `reset` during GAP → all outputs 0 on that edge; a new `start` replays from idx0.
6. With `MELODY_LOOP_EN` and `start` held → after idx4 `note_index` returns to 0, `done` pulses each pass, and DONE is never entered.

Source files
------------

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//
// Plays a fixed table of square-wave notes. Each note sounds for NOTE_TICKS
// cycles and is followed by GAP_TICKS cycles of silence. A free-running
// sample divider latches the current level every SAMPLE_DIV cycles and raises
// write_audio_out. The request is held until audio_out_allowed accepts it.
//
// Optional feature: define MELODY_LOOP_EN to make the table repeat while
// start is held. When it is undefined, the table plays once and then the
// block waits in DONE.
//
// Ports:
//   CLOCK_50          in   single clock
//   reset             in   synchronous, active-high
//   start             in   level; sampled in IDLE/DONE
//   stop              in   level; aborts playback (highest priority)
//   audio_out_allowed in   output FIFO has room; accepts a pending sample
//   write_audio_out   out  pending-sample write strobe
//   sample_out        out  32-bit signed sample (same for both channels)
//   busy              out  high in LOAD/PLAY/GAP
//   note_index        out  current table index
//   done              out  one-cycle pulse at the end of the table
// -----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int NUM_NOTES  = 5,
    parameter int NOTE_TICKS = 50000000,
    parameter int GAP_TICKS  = 2500000,
    parameter int SAMPLE_DIV = 1042,
    parameter int AMPLITUDE  = 10000000,
    // Half-period of each table entry in cycles; 0 is a rest.
    parameter int HALF0      = 95420,
    parameter int HALF1      = 42589,
    parameter int HALF2      = 37936,
    parameter int HALF3      = 42589,
    parameter int HALF4      = 47801,
    parameter int HALF5      = 0,
    parameter int HALF6      = 0,
    parameter int HALF7      = 0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               audio_out_allowed,
    output logic               write_audio_out,
    output logic signed [31:0] sample_out,
    output logic               busy,
    output logic [2:0]         note_index,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [25:0]        NOTE_LAST = 26'(NOTE_TICKS - 1);
    localparam logic [25:0]        GAP_LAST  = 26'(GAP_TICKS - 1);
    localparam logic [10:0]        SAMP_LAST = 11'(SAMPLE_DIV - 1);
    localparam logic [2:0]         LAST_IDX  = 3'(NUM_NOTES - 1);
    localparam logic signed [31:0] AMP_POS   = 32'(AMPLITUDE);

    state_t             state;
    state_t             state_next;
    logic [25:0]        dur_cnt;
    logic [20:0]        half_cnt;
    logic [20:0]        half_period;
    logic [10:0]        samp_cnt;
    logic               phase;
    logic signed [31:0] level;
    logic               dur_term_play;
    logic               dur_term_gap;
    logic               last_note;
    logic               samp_wrap;

    function automatic logic [20:0] half_lookup(input logic [2:0] idx);
        case (idx)
            3'd0:    return 21'(HALF0);
            3'd1:    return 21'(HALF1);
            3'd2:    return 21'(HALF2);
            3'd3:    return 21'(HALF3);
            3'd4:    return 21'(HALF4);
            3'd5:    return 21'(HALF5);
            3'd6:    return 21'(HALF6);
            default: return 21'(HALF7);
        endcase
    endfunction

    // Square-wave level for the current half-cycle; rests are silent.
    function automatic logic signed [31:0] square_level(input logic ph,
                                                        input logic rest);
        if (rest)
            return 32'sd0;
        return ph ? -AMP_POS : AMP_POS;
    endfunction

    assign dur_term_play = (dur_cnt == NOTE_LAST);
    assign dur_term_gap  = (dur_cnt == GAP_LAST);
    assign last_note     = (note_index == LAST_IDX);
    assign samp_wrap     = busy && (samp_cnt == SAMP_LAST);

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_next = S_LOAD;
                S_LOAD: state_next = S_PLAY;
                S_PLAY: if (dur_term_play) state_next = S_GAP;
                S_GAP: begin
                    if (dur_term_gap) begin
                        if (last_note) begin
`ifdef MELODY_LOOP_EN
                            state_next = start ? S_LOAD : S_IDLE;
`else
                            state_next = S_DONE;
`endif
                        end else begin
                            state_next = S_LOAD;
                        end
                    end
                end
                S_DONE: if (!start) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        busy  = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
        level = 32'sd0;
        if (state == S_PLAY)
            level = square_level(phase, half_period == 21'd0);
    end

    // Sequencer counters and the sample handshake
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            note_index      <= 3'd0;
            half_period     <= 21'd0;
            dur_cnt         <= 26'd0;
            half_cnt        <= 21'd0;
            phase           <= 1'b0;
            samp_cnt        <= 11'd0;
            write_audio_out <= 1'b0;
            sample_out      <= 32'sd0;
            done            <= 1'b0;
        end else if (stop) begin
            // Abort: drop any pending sample and rewind.
            note_index      <= 3'd0;
            dur_cnt         <= 26'd0;
            half_cnt        <= 21'd0;
            phase           <= 1'b0;
            samp_cnt        <= 11'd0;
            write_audio_out <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start)
                        note_index <= 3'd0;
                end
                S_LOAD: begin
                    half_period <= half_lookup(note_index);
                    dur_cnt     <= 26'd0;
                    half_cnt    <= 21'd0;
                    phase       <= 1'b0;
                end
                S_PLAY: begin
                    dur_cnt <= dur_term_play ? 26'd0 : dur_cnt + 26'd1;
                    if (half_period != 21'd0) begin
                        if (half_cnt == 21'(half_period - 21'd1)) begin
                            half_cnt <= 21'd0;
                            phase    <= ~phase;
                        end else begin
                            half_cnt <= half_cnt + 21'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (dur_term_gap) begin
                        dur_cnt <= 26'd0;
                        if (last_note) begin
                            done <= 1'b1;
`ifdef MELODY_LOOP_EN
                            note_index <= 3'd0;
`endif
                        end else begin
                            note_index <= note_index + 3'd1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 26'd1;
                    end
                end
                default: ;
            endcase

            // The divider only runs while busy so the first write lands
            // exactly SAMPLE_DIV cycles after LOAD is entered.
            if (!busy)
                samp_cnt <= 11'd0;
            else if (samp_wrap)
                samp_cnt <= 11'd0;
            else
                samp_cnt <= samp_cnt + 11'd1;

            // A newer wrap overwrites an unaccepted sample; there is no queue.
            if (samp_wrap) begin
                sample_out      <= level;
                write_audio_out <= 1'b1;
            end else if (write_audio_out && audio_out_allowed) begin
                write_audio_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//
// Directed bench for melody_sequencer with short timing parameters
// (NOTE_TICKS=40, GAP_TICKS=8, SAMPLE_DIV=4, half-periods 5,3,0,2,4).
// Edge numbers below count clock edges from the edge that samples start.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam logic signed [31:0] P = 32'sd10000000;
    localparam logic signed [31:0] N = -32'sd10000000;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic               allowed;
    logic               write_audio_out;
    logic signed [31:0] sample_out;
    logic               busy;
    logic [2:0]         note_index;
    logic               done;

    int n_checks;
    int n_fail;
    int edge_n;

    typedef struct {
        logic               start;
        logic               stop;
        logic               allowed;
        logic               busy;
        logic               write;
        logic signed [31:0] sample;
        logic [2:0]         idx;
        logic               done;
    } vec_t;

    vec_t vecs[20];

    melody_sequencer #(
        .NUM_NOTES (5),
        .NOTE_TICKS(40),
        .GAP_TICKS (8),
        .SAMPLE_DIV(4),
        .AMPLITUDE (10000000),
        .HALF0     (5),
        .HALF1     (3),
        .HALF2     (0),
        .HALF3     (2),
        .HALF4     (4)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .audio_out_allowed(allowed),
        .write_audio_out  (write_audio_out),
        .sample_out       (sample_out),
        .busy             (busy),
        .note_index       (note_index),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d",
                     name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Note-0 row: busy, index 0, no done, allowed held high.
    function automatic vec_t mk(input logic st, input logic w,
                                input logic signed [31:0] s);
        vec_t v;
        v.start   = st;
        v.stop    = 1'b0;
        v.allowed = 1'b1;
        v.busy    = 1'b1;
        v.write   = w;
        v.sample  = s;
        v.idx     = 3'd0;
        v.done    = 1'b0;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;

        // Note 0 (half-period 5): phase flips every 5 cycles, sample every 4.
        vecs[0]  = mk(1'b1, 1'b0, 32'sd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'sd0);
        vecs[2]  = mk(1'b0, 1'b0, 32'sd0);
        vecs[3]  = mk(1'b0, 1'b0, 32'sd0);
        vecs[4]  = mk(1'b0, 1'b1, P);
        vecs[5]  = mk(1'b0, 1'b0, P);
        vecs[6]  = mk(1'b0, 1'b0, P);
        vecs[7]  = mk(1'b0, 1'b0, P);
        vecs[8]  = mk(1'b0, 1'b1, N);
        vecs[9]  = mk(1'b0, 1'b0, N);
        vecs[10] = mk(1'b0, 1'b0, N);
        vecs[11] = mk(1'b0, 1'b0, N);
        vecs[12] = mk(1'b0, 1'b1, P);
        vecs[13] = mk(1'b0, 1'b0, P);
        vecs[14] = mk(1'b0, 1'b0, P);
        vecs[15] = mk(1'b0, 1'b0, P);
        vecs[16] = mk(1'b0, 1'b1, P);
        vecs[17] = mk(1'b0, 1'b0, P);
        vecs[18] = mk(1'b0, 1'b0, P);
        vecs[19] = mk(1'b0, 1'b0, P);

        // Reset state
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        allowed = 1'b1;
        repeat (3) step();
        chk("rst_write", write_audio_out, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", note_index, 0);
        chk("rst_done", done, 0);
        reset  = 1'b0;
        step();
        edge_n = 0;

        // Start and the first samples of note 0
        foreach (vecs[i]) begin
            start   = vecs[i].start;
            stop    = vecs[i].stop;
            allowed = vecs[i].allowed;
            step();
            chk($sformatf("t1_busy_%0d", i), busy, vecs[i].busy);
            chk($sformatf("t1_write_%0d", i), write_audio_out, vecs[i].write);
            chk($sformatf("t1_sample_%0d", i), sample_out, vecs[i].sample);
            chk($sformatf("t1_idx_%0d", i), note_index, vecs[i].idx);
            chk($sformatf("t1_done_%0d", i), done, vecs[i].done);
        end

        // Rest of the single pass
        for (int e = 21; e <= 250; e++) begin
            step();
            chk("t2_write_cadence", write_audio_out, (e % 4 == 1) && e < 246);
            chk("t2_done", done, e == 246);
            chk("t2_busy", busy, e < 246);
            for (int k = 1; k <= 4; k++) begin
                if (e == 49 * k)
                    chk("t2_idx_gap_end", note_index, k - 1);
                if (e == 1 + 49 * k)
                    chk("t2_idx_load", note_index, k);
            end
            if (e == 245)
                chk("t2_idx_last", note_index, 4);
            if (e >= 101 && e <= 149 && (e % 4 == 1))
                chk("t2_rest_sample", sample_out, 0);
        end

        // Backpressure mid-note, then stop in note 3 with start high
        edge_n = 0;
        for (int r = 1; r <= 162; r++) begin
            start   = (r == 1) || (r == 161) || (r == 162);
            stop    = (r == 161) || (r == 162);
            allowed = !(r >= 6 && r <= 15);
            step();
            if (r >= 6 && r <= 15)
                chk("t3_write_held", write_audio_out, 1);
            if (r == 8)
                chk("t3_sample_a", sample_out, P);
            if (r == 12)
                chk("t3_sample_b", sample_out, N);
            if (r == 15)
                chk("t3_sample_c", sample_out, P);
            if (r == 16)
                chk("t3_write_accepted", write_audio_out, 0);
            if (r == 17) begin
                chk("t3_write_next", write_audio_out, 1);
                chk("t3_sample_next", sample_out, P);
            end
            if (r == 148)
                chk("t4_idx_note3", note_index, 3);
            if (r == 161) begin
                chk("t4_stop_busy", busy, 0);
                chk("t4_stop_write", write_audio_out, 0);
                chk("t4_stop_idx", note_index, 0);
                chk("t4_stop_done", done, 0);
            end
            if (r == 162)
                chk("t4_stop_over_start", busy, 0);
        end
        start = 1'b0;
        stop  = 1'b0;
        step();

        // Synchronous reset during the GAP of note 1
        edge_n = 0;
        for (int r = 1; r <= 93; r++) begin
            start = (r == 1);
            reset = (r == 93);
            step();
            if (r == 50)
                chk("t5_idx_note1", note_index, 1);
            if (r == 92) begin
                chk("t5_gap_busy", busy, 1);
                chk("t5_gap_idx", note_index, 1);
                chk("t5_gap_sample", sample_out, P);
            end
            if (r == 93) begin
                chk("t5_rst_write", write_audio_out, 0);
                chk("t5_rst_sample", sample_out, 0);
                chk("t5_rst_busy", busy, 0);
                chk("t5_rst_idx", note_index, 0);
                chk("t5_rst_done", done, 0);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        step();

        // Replay with start held high
        edge_n = 0;
        start  = 1'b1;
`ifdef MELODY_LOOP_EN
        for (int r = 1; r <= 500; r++) begin
            step();
            chk("t6_busy_loop", busy, 1);
            chk("t6_done_loop", done, (r == 246) || (r == 491));
            if (r == 5) begin
                chk("t6_first_write", write_audio_out, 1);
                chk("t6_first_sample", sample_out, P);
            end
            if (r == 245)
                chk("t6_idx_last", note_index, 4);
            if (r == 246 || r == 491)
                chk("t6_idx_wrap", note_index, 0);
        end
`else
        for (int r = 1; r <= 260; r++) begin
            step();
            if (r == 1) begin
                chk("t5_replay_busy", busy, 1);
                chk("t5_replay_idx", note_index, 0);
            end
            if (r == 5) begin
                chk("t5_replay_write", write_audio_out, 1);
                chk("t5_replay_sample", sample_out, P);
            end
            chk("t6_done_once", done, r == 246);
            chk("t6_busy", busy, r < 246);
            if (r == 246)
                chk("t6_idx_done", note_index, 4);
        end
        start = 1'b0;
        step();
        chk("t6_done_to_idle", busy, 0);
        start = 1'b1;
        step();
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_idx", note_index, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
